// File: rtl/mc_state_clip_seq_if.sv
// Handshake bundle between mc_state_clip_seq, its upstream step datapath, downstream consumer and Clip32.
// master = sequencer view, slave = environment view (upstream/downstream/Clip32 side).
interface mc_state_clip_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pos;
  logic [31:0] i_vel;
  logic        o_clip_ena;
  logic [31:0] o_clip_data;
  logic [31:0] o_clip_max;
  logic [31:0] o_clip_min;
  logic        i_clip_valid;
  logic [31:0] i_clip_result;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pos;
  logic [31:0] o_vel;
  logic        o_wall_hit;
  logic        o_err;

  modport master (
    input  i_valid, i_pos, i_vel, i_clip_valid, i_clip_result, i_ready,
    output o_ready, o_clip_ena, o_clip_data, o_clip_max, o_clip_min,
           o_valid, o_pos, o_vel, o_wall_hit, o_err
  );

  modport slave (
    output i_valid, i_pos, i_vel, i_clip_valid, i_clip_result, i_ready,
    input  o_ready, o_clip_ena, o_clip_data, o_clip_max, o_clip_min,
           o_valid, o_pos, o_vel, o_wall_hit, o_err
  );
endinterface

// File: rtl/mc_state_clip_seq.sv
// Clip32 initiator: clips velocity then position of one MountainCar state, applies the left-wall rule.
// o_valid at accept+5+2L, one state in flight, OUT held until i_ready; CLIP_TIMEOUT_EN adds a response timeout.
module mc_state_clip_seq #(
  parameter logic [31:0] P_POS_MIN = 32'hBF99999A,
  parameter logic [31:0] P_POS_MAX = 32'h3F19999A,
  parameter logic [31:0] P_VEL_MIN = 32'hBD8F5C29,
  parameter logic [31:0] P_VEL_MAX = 32'h3D8F5C29,
  parameter int          P_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  mc_state_clip_seq_if.master  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_VEL_REQ = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_POS_REQ = 3'd3;
  localparam logic [2:0] S_FIX     = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] pos_in_q, pos_in_d;
  logic [31:0] vel_in_q, vel_in_d;
  logic [31:0] pos_c_q, pos_c_d;
  logic [31:0] vel_c_q, vel_c_d;
  logic [31:0] out_pos_q, out_pos_d;
  logic [31:0] out_vel_q, out_vel_d;
  logic        wall_q, wall_d;
  logic        armed_q, armed_d;

  logic        in_vel_req;
  logic        in_pos_req;
  logic        in_req;
  logic        got;
  logic        tmo;
  logic        req_done;
  logic [31:0] req_raw;
  logic [31:0] req_res;
  logic        wall;
  logic [31:0] vel_fix;

  assign in_vel_req = (state_q == S_VEL_REQ);
  assign in_pos_req = (state_q == S_POS_REQ);
  assign in_req     = in_vel_req | in_pos_req;

  // armed_q is low in the first cycle of a request, masking a valid left over from the previous one
  assign got      = in_req & armed_q & bus.i_clip_valid;
  assign req_done = got | tmo;
  assign req_raw  = in_vel_req ? vel_in_q : pos_in_q;
  assign req_res  = got ? bus.i_clip_result : req_raw;

  // Only a strictly negative velocity is zeroed at the wall; -0.0 passes through
  assign wall    = (pos_c_q == P_POS_MIN);
  assign vel_fix = (wall && vel_c_q[31] && (vel_c_q[30:0] != 31'd0)) ? 32'h0000_0000 : vel_c_q;

`ifdef CLIP_TIMEOUT_EN
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign tmo = in_req & ~got & (cnt_q == CNT_W'(P_TIMEOUT));

  always_comb begin
    cnt_d = in_req ? (cnt_q + CNT_W'(1)) : '0;
    err_d = err_q | tmo;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.o_err = err_q;
`else
  assign tmo       = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pos_in_d  = pos_in_q;
    vel_in_d  = vel_in_q;
    pos_c_d   = pos_c_q;
    vel_c_d   = vel_c_q;
    out_pos_d = out_pos_q;
    out_vel_d = out_vel_q;
    wall_d    = wall_q;
    armed_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          pos_in_d = bus.i_pos;
          vel_in_d = bus.i_vel;
          state_d  = S_VEL_REQ;
        end
      end
      S_VEL_REQ: begin
        armed_d = 1'b1;
        if (req_done) begin
          vel_c_d = req_res;
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = S_POS_REQ;
      S_POS_REQ: begin
        armed_d = 1'b1;
        if (req_done) begin
          pos_c_d = req_res;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        out_pos_d = pos_c_q;
        out_vel_d = vel_fix;
        wall_d    = wall;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      pos_in_q  <= '0;
      vel_in_q  <= '0;
      pos_c_q   <= '0;
      vel_c_q   <= '0;
      out_pos_q <= '0;
      out_vel_q <= '0;
      wall_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_in_q  <= pos_in_d;
      vel_in_q  <= vel_in_d;
      pos_c_q   <= pos_c_d;
      vel_c_q   <= vel_c_d;
      out_pos_q <= out_pos_d;
      out_vel_q <= out_vel_d;
      wall_q    <= wall_d;
      armed_q   <= armed_d;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_valid     = (state_q == S_OUT);
  assign bus.o_clip_ena  = in_req;
  assign bus.o_clip_data = in_vel_req ? vel_in_q  : (in_pos_req ? pos_in_q  : 32'h0);
  assign bus.o_clip_max  = in_vel_req ? P_VEL_MAX : (in_pos_req ? P_POS_MAX : 32'h0);
  assign bus.o_clip_min  = in_vel_req ? P_VEL_MIN : (in_pos_req ? P_POS_MIN : 32'h0);
  assign bus.o_pos       = out_pos_q;
  assign bus.o_vel       = out_vel_q;
  assign bus.o_wall_hit  = wall_q;

endmodule
